alu_mp_sequencer: RTL and testbench
===================================

// Module: alu_mp_sequencer
// PURPOSE
//  Multi-precision arithmetic sequencer for the 8-bit ALU operand-mux/adder datapath.
//  Runs ADD/ADC/SUB/SBB over NBYTES-byte operands, one byte per cycle, LSB first.
//  Each cycle it presents a byte index to the operand register file and drives the
//  mux selector S and carry-in, chaining the adder carry across bytes.
//  Writes each result byte back and reports the final carry/borrow and zero flags.
// PARAMETERS
//  NBYTES  4  operand length in bytes; legal range 1..16
//  IW      4  byte-index width; ceil(log2(NBYTES)), min 1
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   request an operation; sampled in IDLE only
//  op         in   2   00 ADD, 01 ADC, 10 SUB, 11 SBB; latched on accepted start
//  cin_ext    in   1   carry-in (ADC) / borrow-in (SBB); latched on accepted start
//  byte_idx   out  IW  byte index to operand RF (A and B read combinationally)
//  alu_s      out  2   selector to ALU operand mux (00 B,c=0; 01 B,c=cin; 10 ~B,c=1; 11 ~B,c=~cin)
//  alu_cin    out  1   carry-in to ALU operand mux
//  sum_in     in   8   adder sum for the current byte
//  cout_in    in   1   adder carry-out for the current byte
//  res_we     out  1   result byte write enable
//  res_idx    out  IW  result byte index (equals byte_idx)
//  res_byte   out  8   result byte (equals sum_in while res_we=1)
//  busy       out  1   high from the cycle after an accepted start through DONE
//  done       out  1   one-cycle pulse in DONE
//  c_flag     out  1   final carry (ADD/ADC) or borrow (SUB/SBB); held until next done
//  z_flag     out  1   1 if all result bytes are zero; held until next done
// BEHAVIOUR
//  Reset: state IDLE; byte_idx=0, alu_s=00, alu_cin=0, res_we=0, busy=0, done=0,
//   c_flag=0, z_flag=0; internal carry register and zero accumulator cleared.
//  FSM IDLE -> RUN on start=1 (op and cin_ext latched); RUN -> DONE after byte NBYTES-1;
//   DONE -> IDLE unconditionally. start is ignored outside IDLE, with no queueing.
//  RUN cycle k (k=0..NBYTES-1): byte_idx=k, res_we=1, res_byte=sum_in.
//   Byte 0 drives: ADD s=00; ADC s=01,cin=cin_ext; SUB s=10; SBB s=11,cin=cin_ext.
//   Byte k>0 drives: add ops s=01,cin=cr; sub ops s=11,cin=~cr, so the mux restores cr.
//   cr <= cout_in at each RUN edge. zacc <= zacc & (sum_in==0); zacc is set to 1 on start.
//  DONE: done=1, busy=1, res_we=0. c_flag <= cr for add ops and ~cr for sub ops.
//   z_flag <= zacc. Flags update only on entry to DONE.
//  Latency: start accepted at edge t0 -> RUN cycles t0..t0+NBYTES-1 -> done at t0+NBYTES.
//   Back-to-back starts are possible every NBYTES+2 cycles.
//  Outside RUN: alu_s=00, alu_cin=0, byte_idx=0, res_we=0.
//  Reset asserted mid-RUN aborts immediately; partial writes already issued stand.
//   Flags revert to 0 and no done pulse is produced.
//  NBYTES=1: single RUN cycle using the byte-0 encoding only.
//  byte_idx wraps to 0 on leaving RUN; no out-of-range index is ever driven.
// TESTING (NBYTES=4; bench models the mux+adder and a 4-byte A/B/R RF)
//  ADD A=0x000000FF B=0x00000001 -> R=0x00000100, c_flag=0, z_flag=0, done at t0+4.
//  SUB A=0x00000000 B=0x00000001 -> R=0xFFFFFFFF, c_flag(borrow)=1, z_flag=0;
//   alu_s sequence is 10,11,11,11.
//  ADC cin_ext=1 A=0xFFFFFFFF B=0 -> R=0x00000000, c_flag=1, z_flag=1.
//  SBB cin_ext=1 A=0x00000100 B=0 -> R=0x000000FF, c_flag=0; byte 0 drives s=11, alu_cin=1.
//  start held high through RUN -> exactly one operation; busy=1 for 5 cycles, one done pulse.
//  rst_n low during RUN byte 2 -> busy=0, res_we=0 asynchronously, flags 0, no done;
//   a following ADD runs normally.

Source files
------------

// File: rtl/alu_mp_sequencer.sv
// Multi-precision ADD/ADC/SUB/SBB sequencer driving an 8-bit operand-mux/adder datapath,
// one byte per cycle LSB first, with the carry chained through the mux selector.
module alu_mp_sequencer #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned IW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic          cin_ext,
    output logic [IW-1:0] byte_idx,
    output logic [1:0]    alu_s,
    output logic          alu_cin,
    input  logic [7:0]    sum_in,
    input  logic          cout_in,
    output logic          res_we,
    output logic [IW-1:0] res_idx,
    output logic [7:0]    res_byte,
    output logic          busy,
    output logic          done,
    output logic          c_flag,
    output logic          z_flag
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic          zacc_q, zacc_d;
    logic [IW-1:0] byte_idx_d;
    logic [1:0]    alu_s_d;
    logic          alu_cin_d;
    logic          res_we_d;
    logic          busy_d;
    logic          done_d;
    logic          c_flag_d;
    logic          z_flag_d;

    // Result path is a direct pass-through of the adder for the byte being processed.
    assign res_byte = sum_in;
    assign res_idx  = byte_idx;

    // Next-state and next-output logic; all outputs below are registered.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        zacc_d     = zacc_q;
        byte_idx_d = '0;
        alu_s_d    = 2'b00;
        alu_cin_d  = 1'b0;
        res_we_d   = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        c_flag_d   = c_flag;
        z_flag_d   = z_flag;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    op_d      = op;
                    zacc_d    = 1'b1;
                    res_we_d  = 1'b1;
                    busy_d    = 1'b1;
                    // Byte-0 selector encoding coincides with the op code itself.
                    alu_s_d   = op;
                    alu_cin_d = op[0] & cin_ext;
                end
            end
            RUN: begin
                zacc_d = zacc_q & (sum_in == 8'h00);
                busy_d = 1'b1;
                if (byte_idx == LAST_IDX) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    c_flag_d = cout_in ^ op_q[1];
                    z_flag_d = zacc_d;
                end else begin
                    byte_idx_d = byte_idx + IW'(1);
                    res_we_d   = 1'b1;
                    // Sub ops invert cin so the mux's c=~cin restores the raw carry.
                    alu_s_d    = {op_q[1], 1'b1};
                    alu_cin_d  = cout_in ^ op_q[1];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            zacc_q   <= 1'b0;
            byte_idx <= '0;
            alu_s    <= 2'b00;
            alu_cin  <= 1'b0;
            res_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            zacc_q   <= zacc_d;
            byte_idx <= byte_idx_d;
            alu_s    <= alu_s_d;
            alu_cin  <= alu_cin_d;
            res_we   <= res_we_d;
            busy     <= busy_d;
            done     <= done_d;
            c_flag   <= c_flag_d;
            z_flag   <= z_flag_d;
        end
    end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Bench for alu_mp_sequencer: models the operand mux, adder and A/B/R register files,
// with a scoreboard checked by a monitor on every done pulse.
module tb_alu_mp_sequencer;

    localparam int unsigned NB = 4;
    localparam int unsigned IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          cin_ext = 1'b0;
    logic [IW-1:0] byte_idx;
    logic [1:0]    alu_s;
    logic          alu_cin;
    logic [7:0]    sum_in;
    logic          cout_in;
    logic          res_we;
    logic [IW-1:0] res_idx;
    logic [7:0]    res_byte;
    logic          busy;
    logic          done;
    logic          c_flag;
    logic          z_flag;

    alu_mp_sequencer #(.NBYTES(NB), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cin_ext(cin_ext),
        .byte_idx(byte_idx), .alu_s(alu_s), .alu_cin(alu_cin),
        .sum_in(sum_in), .cout_in(cout_in), .res_we(res_we), .res_idx(res_idx),
        .res_byte(res_byte), .busy(busy), .done(done), .c_flag(c_flag), .z_flag(z_flag)
    );

    always #5 clk = ~clk;

    // Operand register file and mux+adder model
    logic [7:0] a_rf [NB];
    logic [7:0] b_rf [NB];
    logic [7:0] bm;
    logic       cm;
    logic [1:0] bi;

    always_comb begin
        bi = byte_idx[1:0];
        bm = alu_s[1] ? ~b_rf[bi] : b_rf[bi];
        case (alu_s)
            2'b00:   cm = 1'b0;
            2'b01:   cm = alu_cin;
            2'b10:   cm = 1'b1;
            default: cm = ~alu_cin;
        endcase
        {cout_in, sum_in} = 9'(a_rf[bi]) + 9'(bm) + 9'(cm);
    end

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic [7:0]  sseq;
        logic        cin0;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: captures result writes and selector trace, compares on done
    logic [7:0] r_rf [NB];
    logic [7:0] sseq;
    logic       cin0;
    int         bcnt = 0;
    logic       busy_p = 1'b0;
    exp_t       e;

    always @(negedge clk) begin
        if (busy && !busy_p) begin
            for (int i = 0; i < NB; i++) r_rf[i] = 8'h00;
            sseq = 8'h00;
            cin0 = 1'b0;
            bcnt = 0;
        end
        if (busy) bcnt++;
        if (res_we) begin
            r_rf[res_idx[1:0]] = res_byte;
            sseq[2*int'(res_idx[1:0]) +: 2] = alu_s;
            if (res_idx == '0) cin0 = alu_cin;
        end
        if (done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pending op");
            end else begin
                e = sbq.pop_front();
                chk("result", {r_rf[3], r_rf[2], r_rf[1], r_rf[0]}, e.r);
                chk("c_flag", 32'(c_flag), 32'(e.c));
                chk("z_flag", 32'(z_flag), 32'(e.z));
                chk("alu_s_seq", 32'(sseq), 32'(e.sseq));
                chk("byte0_cin", 32'(cin0), 32'(e.cin0));
                chk("busy_cycles", 32'(bcnt), 32'(NB + 1));
            end
        end
        busy_p = busy;
    end

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < NB; i++) begin
            a_rf[i] = a[8*i +: 8];
            b_rf[i] = b[8*i +: 8];
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic ci, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic c,
                          input logic z, input logic [7:0] ss, input logic c0,
                          input bit hold);
        exp_t x;
        int n;
        x.r = r; x.c = c; x.z = z; x.sseq = ss; x.cin0 = c0;
        load_ops(a, b);
        sbq.push_back(x);
        @(negedge clk);
        start = 1'b1;
        op = o;
        cin_ext = ci;
        @(posedge clk);
        if (hold) repeat (NB) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done within 20 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NB; i++) begin
            a_rf[i] = 8'h00;
            b_rf[i] = 8'h00;
            r_rf[i] = 8'h00;
        end
        sseq = 8'h00;
        cin0 = 1'b0;

        #3;
        chk("rst_byte_idx", 32'(byte_idx), 32'd0);
        chk("rst_alu_s", 32'(alu_s), 32'd0);
        chk("rst_outs", 32'({alu_cin, res_we, busy, done, c_flag, z_flag}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(2'b00, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 8'h54, 1'b0, 1'b0);
        run_op(2'b10, 1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        run_op(2'b01, 1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0);

        // Abort an SBB during byte 2 with an asynchronous reset
        load_ops(32'h00000100, 32'h00000000);
        @(negedge clk);
        start = 1'b1;
        op = 2'b11;
        cin_ext = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(res_we && byte_idx == IW'(2)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL abort_wait: got no byte 2 want byte 2 within 20 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res_we", 32'(res_we), 32'd0);
        chk("abort_flags", 32'({c_flag, z_flag}), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_byte_idx", 32'(byte_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_idle", 32'({busy, done}), 32'd0);

        run_op(2'b00, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 8'h54, 1'b0, 1'b0);
        run_op(2'b11, 1'b1, 32'h00000100, 32'h00000000, 32'h000000FF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(2'b10, 1'b0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 8'h54, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        run_op(2'b01, 1'b0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
        run_op(2'b11, 1'b0, 32'h00000010, 32'h00000001, 32'h0000000F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
